seq_gen: RTL and testbench
==========================

Name: seq_gen

Overview:
- Serial pattern transmitter. Produces the single-bit `w` stream consumed by the lab FSM sequence detector.
- Captures a parallel pattern on a start pulse and shifts it out MSB-first, one bit per clock.
- Reports busy/done and a 4-bit state code for the existing 7-segment hex decoder.
- On the board: sits between SW/KEY inputs and the detector's `w` input, so test sequences are generated rather than toggled by hand.

Parameters:
- WIDTH, 8, maximum pattern length in bits (legal range 1..15).
- LW, $clog2(WIDTH+1), width of the length field (derived; do not override).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request transmission; sampled only in IDLE.
- pattern  input  WIDTH  bits to send; pattern[len-1] is sent first, pattern[0] last.
- len  input  LW  number of bits to send; values above WIDTH clamp to WIDTH.
- w  output  1  serial data to the detector; registered; idle level 0.
- busy  output  1  high from the first transmitted bit through the last.
- done  output  1  one-cycle pulse after the last bit.
- state  output  4  state code for hex display: IDLE=0, SHIFT=1, DONE=2.
- bits_left  output  LW  remaining bits including the current one; 0 when idle.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; w=0, busy=0, done=0, bits_left=0.
  - Shift register cleared.
  - rst has priority over every other input.
- IDLE:
  - w=0.
  - On a start=1 edge with clamped len>0: load the shift register with pattern left-aligned, i.e. pattern << (WIDTH-len); set cnt=len; go to SHIFT.
  - On a start=1 edge with len=0: go directly to DONE and emit no bits.
- SHIFT:
  - Every cycle w = shreg[WIDTH-1] (registered); shreg shifts left by 1, filling with 0; cnt decrements.
  - Transition to DONE on the edge where cnt==1.
  - start and pattern/len changes are ignored in this state.
- DONE:
  - Lasts exactly one cycle: done=1, w=0, busy=0.
  - Always returns to IDLE.
  - start asserted in DONE is ignored; it is accepted on the following IDLE cycle.
- Latency: start is sampled at edge N.
  - First bit is valid on w during cycle N+1.
  - Last bit is valid during cycle N+len.
  - done is high during cycle N+len+1.
- Minimum gap between transmissions: 2 cycles (DONE, IDLE).
- Reset during SHIFT: transmission aborts immediately; w=0 from the next cycle; no done pulse.
- Level-held start produces back-to-back transmissions separated by the 2-cycle gap. Pattern and len are re-sampled each time.

Optional Feature:
- Macro: SEQ_GEN_LOOP_EN.
- Defined: if start=1 on the edge where the last bit shifts (cnt==1), reload from the current pattern/len and remain in SHIFT with no gap.
  - done pulses for one cycle, coincident with the first bit of the next pass.
  - busy stays high.
  - If the reloaded len is 0, go to DONE as normal.
- Undefined: start during SHIFT is always ignored; the 2-cycle gap always applies.

Decomposition:
- Package seq_pkg holds:
  - state encodings (ST_IDLE=4'd0, ST_SHIFT=4'd1, ST_DONE=4'd2), matching the hex display codes;
  - the length-clamp function.
- One natural sub-module: piso_shreg, a parallel-in/serial-out shift register with load, shift and clear.
- The FSM and counter stay in seq_gen.

Test Plan:
- rst high 2 cycles, then low -> w=0, busy=0, done=0, state=0, bits_left=0.
- pattern=8'b1011_0110, len=8, start pulse at edge N -> w = 1,0,1,1,0,1,1,0 in cycles N+1..N+8; busy high in those cycles; done=1 only in N+9; state goes 1 then 2 then 0.
- pattern=8'b0000_0101, len=3 -> w = 1,0,1; done in cycle N+4. Repeat with len=12 -> clamped to 8 bits.
- len=0, start pulse -> w stays 0, busy stays 0, done=1 in cycle N+1.
- Start pulse mid-SHIFT ignored, with a new pattern presented -> original 8 bits complete unchanged. Then rst at bit 4 of a fresh transmission -> w=0 next cycle, state=0, no done pulse.
- SEQ_GEN_LOOP_EN defined, start held high, pattern=4'b1101, len=4 -> continuous 1,1,0,1,1,1,0,1…; busy never drops; done pulses every 4 cycles. Feed w into the detector FSM and check z against its reference model.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter (seq_gen).
// State codes double as the digit shown on the 7-segment hex decoder.
package seq_pkg;

  // FSM state encoding; values are the hex display codes
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SHIFT = 4'd1,
    ST_DONE  = 4'd2
  } state_t;

  // Requested lengths above the register width are sent as a full-width pattern
  function automatic int clamp_len(input int req_len, input int max_len);
    return (req_len > max_len) ? max_len : req_len;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in / serial-out shift register, MSB out first.
// Priority: clear > load > shift. Shifting fills with zeros from the LSB end.
module piso_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  // Register contents: clear, parallel load or shift left by one
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= q << 1;
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter feeding the detector's w input.
// Captures pattern/len on start (in IDLE) and sends pattern[len-1] .. pattern[0],
// one bit per clock, then pulses done for one cycle.
//
// Handshake: start is a level, sampled only on edges where the FSM is in IDLE
// (and, with SEQ_GEN_LOOP_EN, on the edge that shifts the last bit); there is no
// ready/ack -- a held start simply re-triggers as soon as it is sampled again.
//
// All outputs (w, busy, done, state, bits_left) are registered copies of the
// internal FSM view, so they lag the internal state by one clock. This gives
// first bit in cycle N+1, last bit in N+len, done in N+len+1 for start at edge N.
//
// Optional build macro: SEQ_GEN_LOOP_EN -- start on the last-bit edge reloads
// and keeps shifting with no gap; done then coincides with the next first bit.
module seq_gen
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  output logic             w,
  output logic             busy,
  output logic             done,
  output logic [3:0]       state,
  output logic [LW-1:0]    bits_left
);

  state_t           st, st_nxt;
  logic [LW-1:0]    cnt, cnt_nxt;
  logic [LW-1:0]    len_c;
  logic [LW-1:0]    sh_amt;
  logic [WIDTH-1:0] load_val;
  logic             sh_load, sh_shift, sh_msb;
  logic             reload, reload_q;

  logic             w_d, busy_d, done_d;
  logic [3:0]       state_d;
  logic [LW-1:0]    bits_d;

  // Clamp the requested length and left-align the pattern so bit len-1 is at the MSB
  assign len_c    = LW'(clamp_len(int'(len), WIDTH));
  assign sh_amt   = LW'(WIDTH) - len_c;
  assign load_val = pattern << sh_amt;

  piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .clear (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (load_val),
    .msb   (sh_msb)
  );

  // State register, bit counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      cnt       <= '0;
      reload_q  <= 1'b0;
      w         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      state     <= 4'd0;
      bits_left <= '0;
    end else begin
      st        <= st_nxt;
      cnt       <= cnt_nxt;
      reload_q  <= reload;
      w         <= w_d;
      busy      <= busy_d;
      done      <= done_d;
      state     <= state_d;
      bits_left <= bits_d;
    end
  end

  // Next-state, counter and shift-register control
  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    reload   = 1'b0;
    case (st)
      ST_IDLE: begin
        if (start) begin
          if (len_c != '0) begin
            sh_load = 1'b1;
            cnt_nxt = len_c;
            st_nxt  = ST_SHIFT;
          end else begin
            st_nxt  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        sh_shift = 1'b1;
        cnt_nxt  = cnt - LW'(1);
        if (cnt <= LW'(1)) begin
          st_nxt = ST_DONE;
`ifdef SEQ_GEN_LOOP_EN
          // Back-to-back pass: reload on the last-bit edge when start is held
          if (start && (len_c != '0)) begin
            reload  = 1'b1;
            sh_load = 1'b1;
            cnt_nxt = len_c;
            st_nxt  = ST_SHIFT;
          end
`endif
        end
      end
      ST_DONE: begin
        st_nxt = ST_IDLE;
      end
      default: begin
        st_nxt = ST_IDLE;
      end
    endcase
  end

  // Output values to be registered on the next edge
  always_comb begin
    w_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = reload_q;
    state_d = st;
    bits_d  = '0;
    case (st)
      ST_SHIFT: begin
        w_d    = sh_msb;
        busy_d = 1'b1;
        bits_d = cnt;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        w_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: directed literal checks plus randomized traffic scored
// against a per-cycle timeline of expected outputs.
module tb_seq_gen;

  localparam int W    = 8;
  localparam int LW   = $clog2(W + 1);
  localparam int MAXC = 4000;
`ifdef SEQ_GEN_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  pattern;
  logic [LW-1:0] len;
  logic          w, busy, done;
  logic [3:0]    state;
  logic [LW-1:0] bits_left;

  always #5 clk = ~clk;

  seq_gen #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .w         (w),
    .busy      (busy),
    .done      (done),
    .state     (state),
    .bits_left (bits_left)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  // expected outputs for the cycle following edge k
  logic          ew [MAXC];
  logic          eb [MAXC];
  logic          edn[MAXC];
  logic [3:0]    es [MAXC];
  logic [LW-1:0] el [MAXC];

  int edge_no     = 0;
  int next_accept = 1;
  int last_edge   = -1;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, edge_no, act, exp);
    end
  endtask

  task automatic set_idle(input int k);
    if (k < MAXC) begin
      ew[k] = 1'b0; eb[k] = 1'b0; edn[k] = 1'b0; es[k] = 4'd0; el[k] = '0;
    end
  endtask

  // Timeline of one transmission of L bits accepted at edge e
  task automatic plan(input int e, input logic [W-1:0] p, input int L);
    for (int k = 1; k <= L; k++) begin
      if (e + k < MAXC) begin
        ew[e+k] = p[L-k]; eb[e+k] = 1'b1; edn[e+k] = 1'b0;
        es[e+k] = 4'd1;   el[e+k] = LW'(L - k + 1);
      end
    end
    if (e + L + 1 < MAXC) begin
      ew[e+L+1] = 1'b0; eb[e+L+1] = 1'b0; edn[e+L+1] = 1'b1;
      es[e+L+1] = 4'd2; el[e+L+1] = '0;
    end
    next_accept = e + L + 2;
    last_edge   = (L > 0) ? e + L : -1;
  endtask

  initial begin
    for (int k = 0; k < MAXC; k++) set_idle(k);
  end

  // Behavioural model: decides at each edge whether a transmission begins
  always @(posedge clk) begin
    int L;
    edge_no = edge_no + 1;
    L = (int'(len) > W) ? W : int'(len);
    if (rst) begin
      for (int k = edge_no; k < edge_no + 24; k++) set_idle(k);
      next_accept = edge_no + 1;
      last_edge   = -1;
    end else if (start && edge_no >= next_accept) begin
      plan(edge_no, pattern, L);
    end else if (LOOP && start && edge_no == last_edge) begin
      plan(edge_no, pattern, L);
      if (L > 0 && edge_no + 1 < MAXC) edn[edge_no+1] = 1'b1;
    end
  end

  // Per-cycle comparison against the timeline
  always @(negedge clk) begin
    if (edge_no >= 1 && edge_no < MAXC) begin
      check("w",         int'(w),         int'(ew[edge_no]));
      check("busy",      int'(busy),      int'(eb[edge_no]));
      check("done",      int'(done),      int'(edn[edge_no]));
      check("state",     int'(state),     int'(es[edge_no]));
      check("bits_left", int'(bits_left), int'(el[edge_no]));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge of cycle N (start sampled at edge N)
  task automatic send(input logic [W-1:0] p, input int l);
    pattern = p;
    len     = LW'(l);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Checks an MSB-first bit stream of n bits in cycles N+1..N+n, then done
  task automatic expect_stream(input string nm, input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      check({nm, "_w"},    int'(w),    int'(bits[i]));
      check({nm, "_busy"}, int'(busy), 1);
    end
    @(negedge clk);
    check({nm, "_done"},  int'(done),  1);
    check({nm, "_state"}, int'(state), 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] exp_bits;
    rst = 1'b1; start = 1'b0; pattern = '0; len = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_w", int'(w), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(state), 0);
    check("rst_bits_left", int'(bits_left), 0);

    // full-length pattern
    send(8'b1011_0110, 8);
    exp_bits = 16'b1011_0110;
    expect_stream("p8", exp_bits, 8);
    @(negedge clk);
    check("p8_idle_state", int'(state), 0);

    // short pattern: only pattern[2:0] is sent
    send(8'b0000_0101, 3);
    exp_bits = 16'b101;
    expect_stream("p3", exp_bits, 3);
    @(negedge clk);

    // over-long request clamps to 8 bits
    send(8'b0000_0101, 12);
    exp_bits = 16'b0000_0101;
    expect_stream("p12", exp_bits, 8);
    @(negedge clk);

    // zero length: straight to done
    send(8'hff, 0);
    @(negedge clk);
    check("l0_done", int'(done), 1);
    check("l0_busy", int'(busy), 0);
    check("l0_w", int'(w), 0);
    @(negedge clk);

    // start with a new pattern mid-transmission is ignored
    send(8'b1100_1010, 8);
    exp_bits = 16'b1100_1010;
    for (int i = 7; i >= 0; i--) begin
      if (i == 5) begin
        pattern = 8'h00; len = LW'(3); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check("mid_w", int'(w), int'(exp_bits[i]));
    end
    start = 1'b0;
    @(negedge clk);
    check("mid_done", int'(done), 1);
    @(negedge clk);

    // reset while bit 4 is due: abort, no done
    send(8'hff, 8);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_w", int'(w), 0);
    check("abort_state", int'(state), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
    end

`ifdef SEQ_GEN_LOOP_EN
    // held start loops 1101 continuously with done every 4 cycles
    pattern = 8'b0000_1101; len = LW'(4); start = 1'b1;
    @(negedge clk);
    exp_bits = 16'b1101;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("loop_w", int'(w), int'(exp_bits[3 - (i % 4)]));
      check("loop_busy", int'(busy), 1);
      check("loop_done", int'(done), (i % 4 == 0 && i > 0) ? 1 : 0);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
`endif

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      start   = ($urandom_range(0, 3) == 0);
      pattern = W'($urandom);
      len     = LW'($urandom_range(0, 15));
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // run-time bound
  initial begin
    #(MAXC * 10);
    n_bad++;
    $display("FAIL timeout: got no end of stimulus, required end before cycle %0d", MAXC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
